// File: rtl/seq_det_scheduler_pkg.sv
// Shared types for the sequence-detector scheduler.
package seq_det_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DRAIN,
        ST_RESP
    } state_t;

    function automatic int unsigned next_idx(
        input int unsigned i,
        input int unsigned n
    );
        return (i + 1 == n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/seq_det_rr_arbiter.sv
// Combinational round-robin pick: first request at/after ptr, wrapping.
module seq_det_rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    int unsigned    idx;
    logic [IDW-1:0] idx_b;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_b   = '0;
        for (int i = 0; i < N; i++) begin
            idx   = (int'(ptr) + i) % N;
            idx_b = IDW'(idx);
            if (!any && req[idx_b]) begin
                any        = 1'b1;
                gnt[idx_b] = 1'b1;
                gnt_idx    = idx_b;
            end
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one serial sequence detector between N word requesters,
// round-robin, returning the per-frame match count.
module seq_det_scheduler
    import seq_det_scheduler_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int W       = 8,
    parameter  int DET_LAT = 1,
    localparam int IDW     = $clog2(N),
    localparam int CW      = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           det_clr,
    output logic           det_data_in,
    input  logic           det_sequence_detected,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [IDW-1:0] resp_id,
    output logic [CW-1:0]  resp_count,
    output logic           busy
);

    localparam int BW  = $clog2(W);
    localparam int DLW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, id_q, gnt_idx;
    logic [N-1:0]   gnt;
    logic           any;
    logic [W-1:0]   word_q;
    logic [BW-1:0]  bit_q;
    logic [DLW-1:0] drn_q;
    logic [CW-1:0]  cnt_q;
    logic           det_clr_q;
    logic           sample;

    seq_det_rr_arbiter #(.N(N)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        det_data_in = 1'b0;
        resp_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    req_ready = gnt;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_SHIFT;
            ST_SHIFT: begin
                det_data_in = word_q[W-1];
                if (bit_q == BW'(W - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drn_q == DLW'(DET_LAT - 1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flag for bit k arrives DET_LAT cycles later, so the window is shifted.
    assign sample = (state_q == ST_SHIFT && int'(bit_q) >= DET_LAT)
                 || (state_q == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            word_q    <= '0;
            bit_q     <= '0;
            drn_q     <= '0;
            cnt_q     <= '0;
            det_clr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            det_clr_q <= (state_d == ST_CLEAR);
            unique case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        word_q <= req_data[int'(gnt_idx) * W +: W];
                        id_q   <= gnt_idx;
                        ptr_q  <= IDW'(next_idx(32'(gnt_idx), N));
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    drn_q <= '0;
                end
                ST_SHIFT: begin
                    word_q <= word_q << 1;
                    bit_q  <= bit_q + BW'(1);
                end
                ST_DRAIN: drn_q <= drn_q + DLW'(1);
                default: ;
            endcase
            if (sample && det_sequence_detected && cnt_q != CW'(W))
                cnt_q <= cnt_q + CW'(1);
        end
    end

    assign det_clr    = det_clr_q;
    assign resp_id    = id_q;
    assign resp_count = cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with a behavioural overlapping "101" detector.
module tb_seq_det_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        det_clr;
    logic        det_data_in;
    logic        det_sequence_detected = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic [3:0]  resp_count;
    logic        busy;

    seq_det_scheduler #(.N(4), .W(8), .DET_LAT(1)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_ready             (req_ready),
        .det_clr               (det_clr),
        .det_data_in           (det_data_in),
        .det_sequence_detected (det_sequence_detected),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_id               (resp_id),
        .resp_count            (resp_count),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Detector: flag one cycle after the bit that completes "101".
    logic [1:0] hist = '0;
    always @(posedge clk) begin
        if (det_clr) begin
            hist                  <= '0;
            det_sequence_detected <= 1'b0;
        end else begin
            hist                  <= {hist[0], det_data_in};
            det_sequence_detected <= ({hist, det_data_in} == 3'b101);
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int viol = 0;

    always @(negedge clk) begin
        if (rst_n && ((busy && req_ready != 4'b0) || $countones(req_ready) > 1))
            viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with requests already driven.
    task automatic serve(input int g, input int expc, input int stall, input bit drop);
        int n;
        logic [7:0] w, seen;
        n = 0;
        seen = '0;
        #1;
        while (req_ready == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1 << g));
        w = req_data[g*8 +: 8];
        resp_ready = (stall == 0);
        @(posedge clk);
        #1;
        if (drop) req_valid = '0;
        @(negedge clk);
        chk("clr", 32'(det_clr), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen[7-k] = det_data_in;
        end
        chk("bits", 32'(seen), 32'(w));
        @(negedge clk);
        chk("drain_rv", 32'(resp_valid), 0);
        @(negedge clk);
        chk("rv", 32'(resp_valid), 1);
        chk("id", 32'(resp_id), g);
        chk("cnt", 32'(resp_count), expc);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_rv", 32'(resp_valid), 1);
            chk("hold_id", 32'(resp_id), g);
            chk("hold_cnt", 32'(resp_count), expc);
            chk("hold_rr", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("idle", 32'(busy), 0);
    endtask

    typedef struct {
        int         r;
        logic [7:0] d;
        int         c;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{0, 8'hAA, 3};
        tbl[1] = '{0, 8'h05, 1};
        tbl[2] = '{1, 8'h80, 0};
        tbl[3] = '{2, 8'hFF, 0};
        tbl[4] = '{3, 8'h2D, 2};
        tbl[5] = '{1, 8'hB5, 3};
        tbl[6] = '{2, 8'h55, 3};

        // Reset asserted mid-clock
        #3 rst_n = 1'b0;
        #1;
        chk("rst_clr", 32'(det_clr), 1);
        chk("rst_rr", 32'(req_ready), 0);
        chk("rst_rv", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_din", 32'(det_data_in), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_cnt", 32'(resp_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_clr", 32'(det_clr), 0);

        // Single-requester frames, incl. back-to-back 05 then 80
        foreach (tbl[i]) begin
            req_data[tbl[i].r*8 +: 8] = tbl[i].d;
            req_valid = 4'(1 << tbl[i].r);
            serve(tbl[i].r, tbl[i].c, 0, 1'b1);
        end

        // Response back-pressure with a competing request held
        req_data[31:24] = 8'hA5;
        req_valid = 4'b1000;
        serve(3, 2, 5, 1'b0);
        req_valid = '0;
        @(negedge clk);

        // All requesters held: order 0,1,2,3,0
        req_data = {8'h2D, 8'h80, 8'h05, 8'hAA};
        req_valid = 4'b1111;
        serve(0, 3, 0, 1'b0);
        serve(1, 1, 0, 1'b0);
        serve(2, 0, 0, 1'b0);
        serve(3, 2, 0, 1'b0);
        serve(0, 3, 0, 1'b1);

        // Reset during SHIFT bit 4 of req2
        req_data[23:16] = 8'h5A;
        req_valid = 4'b0100;
        #1;
        chk("t6_grant", 32'(req_ready), 32'(4'b0100));
        repeat (6) @(negedge clk);
        chk("t6_bit4", 32'(det_data_in), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_clr", 32'(det_clr), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rv", 32'(resp_valid), 0);
        chk("t6_din", 32'(det_data_in), 0);
        req_data[31:24] = 8'h2D;
        req_valid = 4'b1100;
        repeat (2) @(negedge clk);
        chk("t6_rv2", 32'(resp_valid), 0);
        rst_n = 1'b1;
        serve(2, 2, 0, 1'b0);
        serve(3, 2, 0, 1'b1);

        chk("monitor", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
